// File: rtl/alarm_pkg.sv
// Shared types, BCD limits and the 7-segment table for the alarm-clock controller.
package alarm_pkg;

   typedef enum logic {RUN = 1'b0, RING = 1'b1} state_t;

   localparam logic [7:0] HOUR_MAX = 8'h23;
   localparam logic [7:0] MIN_MAX  = 8'h59;
   localparam logic [7:0] SEC_MAX  = 8'h59;

   // Active-low segments ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      seg_enc = 7'b1111111;
      for (int i = 0; i < 10; i++)
         if (d == 4'(i)) seg_enc = SEG[i];
   endfunction

   // Two-digit BCD increment that wraps to 00 after max
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      if (v == max)
         bcd_inc = 8'h00;
      else if (v[3:0] == 4'd9)
         bcd_inc = {v[7:4] + 4'd1, 4'd0};
      else
         bcd_inc = {v[7:4], v[3:0] + 4'd1};
   endfunction

endpackage

// File: rtl/btn_pulse.sv
// Push-button front end: 2-FF synchroniser, stability debounce, one-cycle pulse on press.
module btn_pulse #(
   parameter int DEBOUNCE_CYC = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYC - 1);

   logic sync1, sync2, stable, stable_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         stable   <= 1'b1;
         stable_q <= 1'b1;
         cnt      <= RELOAD;
      end else begin
         sync1    <= btn;
         sync2    <= sync1;
         stable_q <= stable;
         // Any return to the accepted level restarts the stability window
         if (sync2 == stable) begin
            cnt <= RELOAD;
         end else if (cnt == '0) begin
            stable <= sync2;
            cnt    <= RELOAD;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign press = stable_q & ~stable;

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock sequencer: prescaler, BCD time/alarm counters, ring FSM and digit drive.
//   state | meaning
//   RUN   | idle, buzzer off, button edits allowed
//   RING  | alarm sounding 1 s on / 1 s off, edits ignored
module alarm_clock_ctrl
   import alarm_pkg::*;
#(
   parameter int CLK_HZ       = 50_000_000,
   parameter int DEBOUNCE_CYC = 500_000,
   parameter int RING_MAX_S   = 60,
   parameter int ALARM_RST_H  = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btnhora,
   input  logic       btnmin,
   input  logic       btnapagar,
   input  logic       swinicio,
   input  logic       swmodo,
   output logic [6:0] hora1,
   output logic [6:0] hora2,
   output logic [6:0] min1,
   output logic [6:0] min2,
   output logic       buzzer
);

   localparam int PW = $clog2(CLK_HZ + 1);
   localparam int RW = $clog2(RING_MAX_S + 1);
   localparam logic [PW-1:0] PRESC_LOAD = PW'(CLK_HZ - 1);
   localparam logic [RW-1:0] RING_LAST  = RW'(RING_MAX_S - 1);
   localparam logic [7:0] ALARM_RST_BCD = 8'(((ALARM_RST_H / 10) << 4) + (ALARM_RST_H % 10));

   logic hora_p, min_p, apagar_p;
   logic [PW-1:0] presc;
   logic [7:0] t_hour, t_min, t_sec, a_hour, a_min;
   logic [7:0] hour_n, min_n, sec_n, disp_h, disp_m;
   logic sec_tick, sec_wrap, min_wrap, match;
   logic edit_ok, edit_time, edit_alarm;
   state_t state;
   logic [RW-1:0] ring_cnt;

   btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_hora   (.clk(clk), .reset(reset), .btn(btnhora),   .press(hora_p));
   btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_min    (.clk(clk), .reset(reset), .btn(btnmin),    .press(min_p));
   btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_apagar (.clk(clk), .reset(reset), .btn(btnapagar), .press(apagar_p));

   assign sec_tick = swinicio && (presc == '0);
   assign sec_wrap = (t_sec == SEC_MAX);
   assign min_wrap = (t_min == MIN_MAX);
   assign sec_n    = bcd_inc(t_sec, SEC_MAX);
   assign min_n    = sec_wrap ? bcd_inc(t_min, MIN_MAX) : t_min;
   assign hour_n   = (sec_wrap && min_wrap) ? bcd_inc(t_hour, HOUR_MAX) : t_hour;
   // Compare against the post-carry time so the ring starts exactly at HH:MM:00
   assign match    = sec_tick && sec_wrap && (hour_n == a_hour) && (min_n == a_min);

   assign edit_ok    = (state == RUN);
   assign edit_alarm = edit_ok && swmodo;
   assign edit_time  = edit_ok && !swmodo && !swinicio;

   always_ff @(posedge clk) begin
      if (reset) begin
         presc  <= PRESC_LOAD;
         t_sec  <= 8'h00;
         t_min  <= 8'h00;
         t_hour <= 8'h00;
         a_hour <= ALARM_RST_BCD;
         a_min  <= 8'h00;
      end else begin
         if (edit_time && min_p) begin
            t_min <= bcd_inc(t_min, MIN_MAX);
            t_sec <= 8'h00;
            presc <= PRESC_LOAD;
         end else if (swinicio) begin
            if (sec_tick) begin
               presc  <= PRESC_LOAD;
               t_sec  <= sec_n;
               t_min  <= min_n;
               t_hour <= hour_n;
            end else begin
               presc <= presc - 1'b1;
            end
         end
         if (edit_time && hora_p)  t_hour <= bcd_inc(t_hour, HOUR_MAX);
         if (edit_alarm && hora_p) a_hour <= bcd_inc(a_hour, HOUR_MAX);
         if (edit_alarm && min_p)  a_min  <= bcd_inc(a_min, MIN_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         ring_cnt <= '0;
         buzzer   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               buzzer <= 1'b0;
               if (match && !apagar_p) begin
                  state    <= RING;
                  ring_cnt <= '0;
                  buzzer   <= 1'b1;
               end
            end
            RING: begin
               if (apagar_p) begin
                  state  <= RUN;
                  buzzer <= 1'b0;
               end else if (sec_tick) begin
                  ring_cnt <= ring_cnt + 1'b1;
                  if (ring_cnt == RING_LAST) begin
                     state  <= RUN;
                     buzzer <= 1'b0;
                  end else begin
                     // next count is even exactly when the current one is odd
                     buzzer <= ring_cnt[0];
                  end
               end
            end
            default: begin
               state  <= RUN;
               buzzer <= 1'b0;
            end
         endcase
      end
   end

   assign disp_h = swmodo ? a_hour : t_hour;
   assign disp_m = swmodo ? a_min  : t_min;

   always_ff @(posedge clk) begin
      if (reset) begin
         hora1 <= SEG[0];
         hora2 <= SEG[0];
         min1  <= SEG[0];
         min2  <= SEG[0];
      end else begin
         hora1 <= seg_enc(disp_h[7:4]);
         hora2 <= seg_enc(disp_h[3:0]);
         min1  <= seg_enc(disp_m[7:4]);
         min2  <= seg_enc(disp_m[3:0]);
      end
   end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Scoreboard bench for alarm_clock_ctrl with a 4 Hz "second" and short debounce.
module tb_alarm_clock_ctrl;

   localparam int CLK_HZ = 4;
   localparam int DB     = 3;
   localparam int RMAX   = 5;

   localparam logic [6:0] SEGT [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btnhora = 1'b1, btnmin = 1'b1, btnapagar = 1'b1;
   logic swinicio = 1'b0, swmodo = 1'b0;
   logic [6:0] hora1, hora2, min1, min2;
   logic buzzer;

   int cyc = 0;
   int n_assert = 0;
   int n_fail = 0;
   int e0, t5, e1;

   typedef struct {
      string      name;
      bit         chk_disp;
      logic [6:0] h1, h2, m1, m2;
      bit         chk_buz;
      logic       buz;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;

   alarm_clock_ctrl #(
      .CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DB), .RING_MAX_S(RMAX), .ALARM_RST_H(6)
   ) dut (
      .clk(clk), .reset(reset),
      .btnhora(btnhora), .btnmin(btnmin), .btnapagar(btnapagar),
      .swinicio(swinicio), .swmodo(swmodo),
      .hora1(hora1), .hora2(hora2), .min1(min1), .min2(min2),
      .buzzer(buzzer)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: outputs are stable at the falling edge
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         e_mon = exp_q.pop_front();
         if (e_mon.chk_disp) begin
            n_assert++;
            if ({hora1, hora2, min1, min2} !== {e_mon.h1, e_mon.h2, e_mon.m1, e_mon.m2}) begin
               n_fail++;
               $display("FAIL %s: digits got %h %h %h %h, want %h %h %h %h (cycle %0d)", e_mon.name,
                        hora1, hora2, min1, min2, e_mon.h1, e_mon.h2, e_mon.m1, e_mon.m2, cyc);
            end
         end
         if (e_mon.chk_buz) begin
            n_assert++;
            if (buzzer !== e_mon.buz) begin
               n_fail++;
               $display("FAIL %s: buzzer got %b, want %b (cycle %0d)", e_mon.name, buzzer, e_mon.buz, cyc);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic set_btn(input int w, input logic v);
      case (w)
         0:       btnhora   = v;
         1:       btnmin    = v;
         default: btnapagar = v;
      endcase
   endtask

   task automatic press(input int w, input int lo, input int hi);
      set_btn(w, 1'b0);
      tick(lo);
      set_btn(w, 1'b1);
      tick(hi);
   endtask

   task automatic presses(input int w, input int n);
      repeat (n) press(w, 5, 6);
   endtask

   task automatic exp_disp(input string nm, input int hh, input int mm);
      exp_t e;
      e.name = nm; e.chk_disp = 1'b1; e.chk_buz = 1'b0; e.buz = 1'b0;
      e.h1 = SEGT[hh / 10]; e.h2 = SEGT[hh % 10];
      e.m1 = SEGT[mm / 10]; e.m2 = SEGT[mm % 10];
      exp_q.push_back(e);
   endtask

   task automatic exp_buz(input string nm, input logic b);
      exp_t e;
      e.name = nm; e.chk_disp = 1'b0; e.chk_buz = 1'b1; e.buz = b;
      e.h1 = '0; e.h2 = '0; e.m1 = '0; e.m2 = '0;
      exp_q.push_back(e);
   endtask

   initial begin
      // 1: reset state, alarm default
      tick(2);
      exp_disp("reset_digits", 0, 0);
      exp_buz("reset_buzzer", 1'b0);
      reset = 1'b0;
      swmodo = 1'b1;
      tick(2);
      exp_disp("alarm_default", 6, 0);
      swmodo = 1'b0;
      tick(2);

      // 2: time edits with clock held
      presses(0, 13);
      exp_disp("set_hour_13", 13, 0);
      presses(1, 60);
      exp_disp("min_wrap_no_carry", 13, 0);
      presses(1, 1);
      exp_disp("set_13_01", 13, 1);

      // 3: rollover 23:59 -> 00:00, edit ignored while running
      presses(0, 10);
      presses(1, 58);
      exp_disp("set_23_59", 23, 59);
      swinicio = 1'b1;
      e0 = cyc;
      wait_until(e0 + 232);
      exp_disp("before_midnight", 23, 59);
      press(1, 5, 6);
      exp_disp("midnight_rollover", 0, 0);
      exp_buz("no_ring_midnight", 1'b0);

      // 4: alarm 00:01, ring then stop by button
      swinicio = 1'b0;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
      swmodo = 1'b1;
      presses(0, 18);
      presses(1, 1);
      exp_disp("alarm_00_01", 0, 1);
      swmodo = 1'b0;
      swinicio = 1'b1;
      e0 = cyc;
      wait_until(e0 + 239);
      exp_buz("pre_match", 1'b0);
      exp_disp("time_00_00", 0, 0);
      wait_until(e0 + 240);
      exp_buz("ring_start", 1'b1);
      wait_until(e0 + 241);
      exp_disp("time_00_01", 0, 1);
      wait_until(e0 + 244);
      exp_buz("ring_odd_sec", 1'b0);
      wait_until(e0 + 248);
      exp_buz("ring_even_sec", 1'b1);
      press(2, 5, 1);
      exp_buz("stop_latency", 1'b0);
      wait_until(e0 + 257);
      exp_buz("stopped_in_run", 1'b0);

      // 5: alarm 00:02, ring times out
      swmodo = 1'b1;
      press(1, 5, 6);
      exp_disp("alarm_00_02", 0, 2);
      swmodo = 1'b0;
      t5 = e0 + 480;
      wait_until(t5 - 1);
      exp_buz("pre_match2", 1'b0);
      wait_until(t5);
      exp_buz("ring2_start", 1'b1);
      wait_until(t5 + 8);
      exp_buz("ring2_sec2", 1'b1);
      wait_until(t5 + 12);
      exp_buz("ring2_sec3", 1'b0);
      wait_until(t5 + 16);
      exp_buz("ring2_sec4", 1'b1);
      wait_until(t5 + 20);
      exp_buz("ring2_timeout", 1'b0);
      wait_until(t5 + 24);
      exp_buz("ring2_silent", 1'b0);

      // 6: bounce rejected, reset during ring
      wait_until(t5 + 28);
      swinicio = 1'b0;
      tick(2);
      exp_disp("time_00_02", 0, 2);
      press(0, 2, 8);
      exp_disp("bounce_ignored", 0, 2);
      press(0, 5, 6);
      exp_disp("hour_after_bounce", 1, 2);
      press(1, 5, 6);
      exp_disp("time_01_03", 1, 3);
      swmodo = 1'b1;
      presses(0, 1);
      presses(1, 2);
      exp_disp("alarm_01_04", 1, 4);
      swmodo = 1'b0;
      swinicio = 1'b1;
      e1 = cyc;
      wait_until(e1 + 242);
      exp_buz("ring3_on", 1'b1);
      reset = 1'b1;
      tick(1);
      exp_buz("reset_mid_ring", 1'b0);
      exp_disp("reset_mid_ring_digits", 0, 0);
      reset = 1'b0;
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
